// File: rtl/serial_sub_pkg.sv
// Shared definitions for the serial arithmetic blocks (serial_sub today,
// serial adder/multiplier later).
package serial_sub_pkg;

   // Sequencer state encodings shared by the serial arithmetic family.
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/full_sub.sv
// Full subtractor built from two half subtractors and an OR of their borrows.
module full_sub (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   logic w_d1;
   logic w_b1;
   logic w_b2;

   half_sub u_hs0 (.a(a),    .b(b),   .d(w_d1), .bout(w_b1));
   half_sub u_hs1 (.a(w_d1), .b(bin), .d(d),    .bout(w_b2));

   assign bout = w_b1 | w_b2;

endmodule

// File: rtl/half_sub.sv
// Half subtractor: d = a - b, borrow out when a=0 and b=1.
module half_sub (
   input  logic a,
   input  logic b,
   output logic d,
   output logic bout
);

   assign d    = a ^ b;
   assign bout = ~a & b;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b, one bit per clock, LSB first,
// with a start/busy/done handshake.
module serial_sub
   import serial_sub_pkg::*;
#(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             busy,
   output logic             done
);

   localparam int unsigned CW = $clog2(WIDTH);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [WIDTH-1:0] r_sa;
   logic [WIDTH-1:0] r_sb;
   logic [WIDTH-1:0] r_wd;
   logic [WIDTH-1:0] r_diff;
   logic             r_br;
   logic             r_bout;
   logic             r_busy;
   logic             r_done;
   logic [CW-1:0]    r_cnt;
   logic             w_d;
   logic             w_br_nxt;
   logic             w_load;
   logic             w_shift;
   logic             w_last;

   full_sub u_cell (
      .a    (r_sa[0]),
      .b    (r_sb[0]),
      .bin  (r_br),
      .d    (w_d),
      .bout (w_br_nxt)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   // Next-state and datapath strobes.
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_shift     = 1'b0;
      w_last      = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
               w_load      = 1'b1;
               w_state_nxt = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            w_shift = 1'b1;
            if (r_cnt == CW'(WIDTH - 1)) begin
               w_last      = 1'b1;
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   // Operand shifters, borrow, counter and result/handshake registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sa   <= '0;
         r_sb   <= '0;
         r_wd   <= '0;
         r_br   <= 1'b0;
         r_cnt  <= '0;
         r_diff <= '0;
         r_bout <= 1'b0;
         r_busy <= 1'b0;
         r_done <= 1'b0;
      end else begin
         if (w_load) begin
            r_sa  <= a;
            r_sb  <= b;
            r_br  <= 1'b0;
            r_cnt <= '0;
         end else if (w_shift) begin
            r_sa <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb <= {1'b0, r_sb[WIDTH-1:1]};
            r_wd <= {w_d, r_wd[WIDTH-1:1]};
            r_br <= w_br_nxt;
            if (!w_last) r_cnt <= r_cnt + CW'(1);
         end
         // Result is published only when the final bit lands, never partially.
         if (w_last) begin
            r_diff <= {w_d, r_wd[WIDTH-1:1]};
            r_bout <= w_br_nxt;
         end
         r_busy <= (w_state_nxt == ST_SHIFT);
         r_done <= (w_state_nxt == ST_DONE);
      end
   end

   assign diff = r_diff;
   assign bout = r_bout;
   assign busy = r_busy;
   assign done = r_done;

endmodule

// File: tb/tb_serial_sub.sv
// Directed bench for serial_sub: WIDTH=8 vector table plus corner sequences,
// and an exhaustive WIDTH=4 sweep on a second instance.
module tb_serial_sub;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start8 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0, diff8;
   logic       bout8, busy8, done8;
   logic       start4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0, diff4;
   logic       bout4, busy4, done4;

   int checks   = 0;
   int failures = 0;
   int done4_cnt = 0;
   logic [7:0] last_d8 = '0;
   logic       last_b8 = 1'b0;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic [7:0] d;
      logic       bo;
   } vec_t;
   vec_t vecs[10];

   always #5 clk = ~clk;

   serial_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .diff(diff8), .bout(bout8), .busy(busy8), .done(done8)
   );

   serial_sub #(.WIDTH(4)) u_dut4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
      .diff(diff4), .bout(bout4), .busy(busy4), .done(done4)
   );

   always @(negedge clk) if (done4) done4_cnt++;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endtask

   // Wait for done8 after an accepting edge; checks busy and result hold.
   task automatic wait_done8(input logic [7:0] ed, input logic eb);
      int cyc;
      logic held_ok;
      cyc = 0;
      held_ok = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #1;
         if (done8) begin cyc = i; break; end
         if (busy8 !== 1'b1 || diff8 !== last_d8 || bout8 !== last_b8) held_ok = 1'b0;
      end
      chk("latency8", 32'(cyc), 32'd8);
      chk("hold_during_shift", 32'(held_ok), 32'd1);
      chk("diff8", 32'(diff8), 32'(ed));
      chk("bout8", 32'(bout8), 32'(eb));
      chk("busy_with_done", 32'(busy8), 32'd0);
      last_d8 = ed;
      last_b8 = eb;
   endtask

   task automatic op8(input logic [7:0] ia, input logic [7:0] ib,
                      input logic [7:0] ed, input logic eb);
      start8 = 1'b1; a8 = ia; b8 = ib;
      @(posedge clk); #1;
      start8 = 1'b0;
      chk("busy_after_accept", 32'(busy8), 32'd1);
      wait_done8(ed, eb);
      @(posedge clk); #1;
      chk("done_one_cycle", 32'(done8), 32'd0);
      chk("idle_after_done", 32'(busy8), 32'd0);
   endtask

   task automatic op4(input logic [3:0] ia, input logic [3:0] ib);
      int cyc;
      logic [3:0] ed;
      logic       eb;
      ed = ia - ib;
      eb = (ia < ib);
      @(posedge clk); #1;
      start4 = 1'b1; a4 = ia; b4 = ib;
      @(posedge clk); #1;
      start4 = 1'b0;
      cyc = 0;
      for (int i = 1; i <= 10; i++) begin
         @(posedge clk); #1;
         if (done4) begin cyc = i; break; end
      end
      if (cyc != 4) chk("latency4", 32'(cyc), 32'd4);
      chk($sformatf("diff4 a=%0d b=%0d", ia, ib), 32'(diff4), 32'(ed));
      chk($sformatf("bout4 a=%0d b=%0d", ia, ib), 32'(bout4), 32'(eb));
   endtask

   initial begin
      logic no_done;
      vecs[0] = '{8'd9,   8'd5,   8'h04, 1'b0};
      vecs[1] = '{8'd5,   8'd9,   8'hFC, 1'b1};
      vecs[2] = '{8'd0,   8'd1,   8'hFF, 1'b1};
      vecs[3] = '{8'd0,   8'd0,   8'h00, 1'b0};
      vecs[4] = '{8'hAA,  8'hAA,  8'h00, 1'b0};
      vecs[5] = '{8'hFF,  8'h01,  8'hFE, 1'b0};
      vecs[6] = '{8'h01,  8'hFF,  8'h02, 1'b1};
      vecs[7] = '{8'h80,  8'h7F,  8'h01, 1'b0};
      vecs[8] = '{8'h7F,  8'h80,  8'hFF, 1'b1};
      vecs[9] = '{8'hC3,  8'h3C,  8'h87, 1'b0};

      // Reset state.
      repeat (2) @(posedge clk);
      #1;
      chk("rst_diff", 32'(diff8), 32'd0);
      chk("rst_bout", 32'(bout8), 32'd0);
      chk("rst_busy", 32'(busy8), 32'd0);
      chk("rst_done", 32'(done8), 32'd0);
      chk("rst_diff4", 32'(diff4), 32'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Table-driven vectors.
      for (int i = 0; i < 10; i++) op8(vecs[i].a, vecs[i].b, vecs[i].d, vecs[i].bo);

      // start held high with changing operands during SHIFT and DONE.
      start8 = 1'b1; a8 = 8'd9; b8 = 8'd5;
      @(posedge clk); #1;
      a8 = 8'h33; b8 = 8'h11;
      wait_done8(8'h04, 1'b0);
      @(posedge clk); #1;
      chk("ignored_in_done", 32'(busy8), 32'd0);
      chk("done_drop_held", 32'(done8), 32'd0);
      @(posedge clk); #1;
      chk("accept_first_idle", 32'(busy8), 32'd1);
      start8 = 1'b0;
      wait_done8(8'h22, 1'b0);
      @(posedge clk); #1;

      // Reset at SHIFT cycle 4 aborts without a result.
      start8 = 1'b1; a8 = 8'h5A; b8 = 8'h13;
      @(posedge clk); #1;
      start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      chk("abort_diff", 32'(diff8), 32'd0);
      chk("abort_bout", 32'(bout8), 32'd0);
      chk("abort_busy", 32'(busy8), 32'd0);
      chk("abort_done", 32'(done8), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;
      no_done = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (done8 || busy8) no_done = 1'b0;
      end
      chk("no_done_after_abort", 32'(no_done), 32'd1);
      last_d8 = '0;
      last_b8 = 1'b0;
      op8(8'd200, 8'd100, 8'd100, 1'b0);

      // Exhaustive WIDTH=4 sweep.
      done4_cnt = 0;
      for (int x = 0; x < 16; x++)
         for (int y = 0; y < 16; y++)
            op4(4'(x), 4'(y));
      @(posedge clk); #1;
      chk("done4_count", 32'(done4_cnt), 32'd256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
